clz_denorm: RTL and testbench

Pipelined inverse of the leading-zero-count/normalize path. Takes a normalized word plus its leading-zero count and valid bit, in the form the `clz` tree produces them, and reconstructs the original unnormalized word by shifting right, zero-filled, by the count. It sits on the output side of the fixed-point datapath, after arithmetic on normalized operands. It is a 2-stage valid/ready pipeline with one transfer per cycle.

---
 rtl/clz_denorm.sv | 112 +++++++++++
 tb/tb_clz_denorm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clz_denorm.sv
// clz_denorm: rebuilds an unnormalized word from a normalized mantissa and its
// leading-zero count. The result is a zero-filled shift toward higher bit
// indices (a right shift in value terms), split across two pipeline stages.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake
//   in_mant [0:WIDTH-1]   normalized word, bit 0 is the MSB
//   in_cnt  [0:CW-1]      leading-zero count, bit 0 is the MSB
//   in_nz                 nonzero flag; 0 forces a zero result
//   out_valid / out_ready output handshake
//   out_data [0:WIDTH-1]  reconstructed word, bit 0 is the MSB
//   out_err               in_nz was set but in_mant[0] was clear
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Ready never depends on the same-side valid. While out_valid is
// high and out_ready is low, out_data/out_err hold.
module clz_denorm #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] in_mant,
  input  logic [0:CW-1]    in_cnt,
  input  logic             in_nz,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] out_data,
  output logic             out_err
);

  // Upper count bits (rounded up) are resolved in stage 1, the rest in stage 2.
  localparam int HI_W = (CW + 1) / 2;
  localparam int LO_W = CW - HI_W;

  // Stage registers
  logic             s1_v;
  logic [0:WIDTH-1] s1_data;
  logic [LO_W-1:0]  s1_lo;
  logic             s1_nz;
  logic             s1_err;

  logic             s2_v;
  logic [0:WIDTH-1] s2_data;
  logic             s2_err;

  logic             s1_take;
  logic             s2_take;

  // Count as a plain number; in_cnt bit 0 is already the leftmost/MSB bit.
  logic [CW-1:0]    cnt_val;
  logic [CW-1:0]    hi_shift;
  logic [0:WIDTH-1] s1_word;
  logic             in_err;
  logic [0:WIDTH-1] s2_word;

  assign cnt_val  = in_cnt;
  assign hi_shift = {cnt_val[CW-1 -: HI_W], {LO_W{1'b0}}};

  // With bit 0 as MSB, a value right shift moves in_mant[i] to index i+shift.
  assign s1_word  = in_nz ? (in_mant >> hi_shift) : '0;
  assign in_err   = in_nz & ~in_mant[0];

  assign s2_word  = s1_nz ? (s1_data >> s1_lo) : '0;

  // Advance rules
  assign s2_take  = ~s2_v | out_ready;
  assign s1_take  = ~s1_v | s2_take;
  assign in_ready = s1_take;

  // Stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_lo   <= '0;
      s1_nz   <= 1'b0;
      s1_err  <= 1'b0;
    end else if (s1_take) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_data <= s1_word;
        s1_lo   <= cnt_val[LO_W-1:0];
        s1_nz   <= in_nz;
        s1_err  <= in_err;
      end
    end
  end

  // Stage 2; outputs come straight from these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      s2_data <= '0;
      s2_err  <= 1'b0;
    end else if (s2_take) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_data <= s2_word;
        s2_err  <= s1_err;
      end
    end
  end

  assign out_valid = s2_v;
  assign out_data  = s2_data;
  assign out_err   = s2_err;

endmodule

// File: tb/tb_clz_denorm.sv
// Testbench for clz_denorm (WIDTH=8): directed vectors with hand-computed
// results, a scoreboard queue fed on input acceptance and drained on output
// transfer, backpressure, mid-flight reset and a clz/normalize round trip.
module tb_clz_denorm;

  localparam int W  = 8;
  localparam int CW = 3;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [0:W-1]  in_mant = '0;
  logic [0:CW-1] in_cnt = '0;
  logic          in_nz = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [0:W-1]  out_data;
  logic          out_err;

  clz_denorm #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_cnt    (in_cnt),
    .in_nz     (in_nz),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  // Scoreboard: {err, data} expected per accepted word, in order
  logic [W:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: the transfer seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected", 32'd1, 32'd0);
      else check("sb_data", {23'd0, out_err, out_data}, {23'd0, exp_q.pop_front()});
    end
  end

  // Driver: present one word, hold until accepted (bounded).
  task automatic send(input logic [W-1:0] mant, input logic [CW-1:0] cnt, input logic nz,
                      input logic [W-1:0] exp_data, input logic exp_err);
    bit accepted = 1'b0;
    int guard = 0;
    in_valid = 1'b1;
    in_mant  = mant;
    in_cnt   = cnt;
    in_nz    = nz;
    while (!accepted && guard < 200) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        exp_q.push_back({exp_err, exp_data});
      end
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      guard++;
    end
    if (!accepted) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  function automatic void clz_norm(input logic [7:0] x, output logic [7:0] m, output logic [2:0] c);
    bit found = 1'b0;
    c = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (x[i]) found = 1'b1;
      else if (!found) c = c + 3'd1;
    end
    m = x << c;
  endfunction

  initial begin
    logic [W-1:0] bp_mant;
    logic [7:0] x, m;
    logic [2:0] c;
    int idx;
    int acc;
    bit gap;

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Latency: 0xB0 >> 3 = 0x16
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_mant = 8'hB0; in_cnt = 3'd3; in_nz = 1'b1;
    @(negedge clk);
    check("lat_accept", in_ready, 1);
    exp_q.push_back({1'b0, 8'h16});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_not_yet", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 32'h16);
    check("lat_err", out_err, 0);
    @(posedge clk); #1;
    drain();

    // Boundary, zero and error vectors at full rate
    send(8'hFF, 3'd5, 1'b0, 8'h00, 1'b0);
    send(8'h80, 3'd7, 1'b1, 8'h01, 1'b0);
    send(8'h80, 3'd0, 1'b1, 8'h80, 1'b0);
    send(8'h40, 3'd1, 1'b1, 8'h20, 1'b1);
    send(8'hC5, 3'd4, 1'b1, 8'h0C, 1'b0);
    send(8'hFF, 3'd7, 1'b1, 8'h01, 1'b0);
    drain();

    // Backpressure: 0x80 with cnt 0..3, out_ready low for 4 cycles
    bp_mant = 8'h80;
    idx = 0;
    acc = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_mant = bp_mant; in_cnt = 3'(idx); in_nz = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (cyc >= 2) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data", out_data, 32'h80);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, bp_mant >> idx});
        idx++;
        acc++;
      end
      @(posedge clk); #1;
      if (idx < 4) in_cnt = 3'(idx);
      else in_valid = 1'b0;
    end
    check("bp_accepted", acc, 2);
    check("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    gap = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (!out_valid) gap = 1'b1;
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, bp_mant >> idx});
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 4) in_cnt = 3'(idx);
      else in_valid = 1'b0;
    end
    check("bp_no_gap", gap, 0);
    check("bp_all_sent", idx, 4);
    drain();

    // Mid-flight reset
    out_ready = 1'b0;
    send(8'h80, 3'd1, 1'b1, 8'h40, 1'b0);
    send(8'h80, 3'd2, 1'b1, 8'h20, 1'b0);
    @(negedge clk);
    check("mr_full_valid", out_valid, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mr_out_valid", out_valid, 0);
    check("mr_out_data", out_data, 0);
    check("mr_out_err", out_err, 0);
    check("mr_in_ready", in_ready, 1);
    exp_q.delete();
    @(negedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    gap = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (out_valid) gap = 1'b1;
    end
    check("mr_no_output", gap, 0);
    check("mr_in_ready_after", in_ready, 1);

    // Round trip: clz/normalize model feeding the DUT, random out_ready
    @(posedge clk); #1;
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      x = 8'($urandom_range(1, 255));
      clz_norm(x, m, c);
      send(m, c, 1'b1, x, 1'b0);
    end
    rand_ready = 1'b0;
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
